fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address and instruction width.
REQ-002 Parameter IQ_DEPTH, default 4, SHALL set the number of instruction queue entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-004 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 redirect_valid  in  1  branch/jump redirect request.
REQ-007 redirect_pc  in  XLEN  redirect target.
REQ-008 imem_req_valid  out  1  memory request valid.
REQ-009 imem_req_ready  in  1  memory accepts the request.
REQ-010 imem_req_addr  out  XLEN  request address.
REQ-011 imem_rsp_valid  in  1  response valid.
REQ-012 imem_rsp_data  in  XLEN  response instruction.
REQ-013 if_valid  out  1  queue head valid to decode.
REQ-014 if_ready  in  1  decode accepts the head.
REQ-015 if_pc  out  XLEN  PC of the head entry.
REQ-016 if_instr  out  XLEN  instruction of the head entry.

Function
REQ-017 The fetch PC register SHALL advance by 4 per accepted request (imem_req_valid and imem_req_ready), wrapping modulo 2^XLEN.
REQ-018 At most one memory request SHALL be outstanding; the response SHALL arrive one or more cycles after acceptance, in order.
REQ-019 The state machine SHALL have the states IDLE, REQ, WAIT and DRAIN.
REQ-020 IDLE SHALL move to REQ in the first cycle after rst deasserts.
REQ-021 In REQ, imem_req_valid SHALL be 1 only while the number of queue entries plus outstanding requests is below IQ_DEPTH; acceptance SHALL move the state to WAIT.
REQ-022 In WAIT, imem_rsp_valid SHALL push {request PC, data} into the queue and return the state to REQ, with a new request allowed in the same cycle if the queue has space.
REQ-023 redirect_valid SHALL, in the same cycle, flush the queue (if_valid is 0 next cycle) and load the fetch PC with redirect_pc.
REQ-024 A redirect in WAIT, or coinciding with request acceptance, SHALL enter DRAIN; the next response SHALL be discarded and the state SHALL then be REQ.
REQ-025 A redirect SHALL take priority over a simultaneous push or pop; a redirect during DRAIN SHALL update the PC and remain in DRAIN.
REQ-026 A pop SHALL occur when if_valid and if_ready are both 1; a simultaneous push and pop on a full queue SHALL be legal and keep the count unchanged.
REQ-027 if_pc and if_instr SHALL be driven directly from the queue head register, with no combinational path from imem_rsp_*.
REQ-028 A response received in REQ or IDLE is a protocol error and SHALL be ignored.

Reset
REQ-029 While rst is 1: state SHALL be IDLE, fetch PC SHALL be RESET_PC, queue count 0, imem_req_valid 0, if_valid 0, and imem_req_addr and if_pc SHALL be RESET_PC.
REQ-030 A reset asserted mid-operation SHALL abandon any outstanding request, and the first response after reset SHALL be discarded.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined, the block SHALL add output perf_fetched (32 bits, reset 0, saturating), which increments on every pop, and output perf_flushed (32 bits, reset 0, saturating), which increments by the number of entries discarded on each redirect.
REQ-032 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-033 Package fetch_pkg SHALL hold the fetch_state_t enum and the fetch_entry_t struct {pc, instr}.
REQ-034 The queue SHALL be the sub-module fetch_queue, parametrised by depth and entry type, with push, pop, flush, full, empty and count.

Verification
REQ-035 Release reset with a zero-latency ready memory and if_ready=1 -> imem_req_addr sequence 0x0, 0x4, 0x8; if_pc matches each with its data.
REQ-036 Hold if_ready=0 with IQ_DEPTH=4 -> exactly 4 entries queued, then imem_req_valid=0; raise if_ready -> fetching resumes at 0x10.
REQ-037 Redirect to 0x100 while in WAIT -> the stale response is discarded, the next request address is 0x100, and if_valid is 0 for at least one cycle.
REQ-038 Set fetch PC to 0xFFFFFFFC with XLEN=32 -> the next request address is 0x00000000.
REQ-039 Assert rst with a request outstanding -> outputs reach their reset values, the late response is discarded, and fetching restarts at RESET_PC.
REQ-040 With FETCH_PERF_CNT_EN defined, pop 5 entries then redirect with 3 queued -> perf_fetched=5 and perf_flushed=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, queue entry
// layout and a saturating adder used by the optional perf counters.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Entries are sized for the widest supported XLEN; narrower builds
    // zero-extend, and the constant upper bits fall away in synthesis.
    localparam int FETCH_XLEN_MAX = 64;

    typedef struct packed {
        logic [FETCH_XLEN_MAX-1:0] pc;
        logic [FETCH_XLEN_MAX-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two circular instruction queue with flush; a simultaneous push
// and pop on a full queue is accepted and leaves the count unchanged.
module fetch_queue #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // NOTE: non-blocking assignments for every register so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, queued responses
// to decode, redirect flush. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              IQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    if (IQ_DEPTH < 2 || (IQ_DEPTH & (IQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_unit: IQ_DEPTH must be a power of two and at least 2");
    end
    if (XLEN > FETCH_XLEN_MAX) begin : g_bad_xlen
        $error("fetch_unit: XLEN exceeds FETCH_XLEN_MAX");
    end

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            rst_stale;
    logic            req_valid_c;
    logic            accept;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    push_entry;

    assign accept = imem_req_valid && imem_req_ready;
    assign pop    = if_valid && if_ready && !redirect_valid;

    // A WAIT-cycle request may go out only if the arriving response plus the new one still fit.
    // rst_stale holds off requests until the response abandoned by a reset has been swallowed.
    always_comb begin
        req_valid_c = 1'b0;
        case (state)
            REQ:     req_valid_c = !q_full && !rst_stale;
            WAIT:    req_valid_c = imem_rsp_valid && (q_count < CW'(IQ_DEPTH - 1));
            default: req_valid_c = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ:   if (accept) state_nxt = WAIT;
            WAIT:  if (imem_rsp_valid) begin
                       push      = 1'b1;
                       state_nxt = accept ? WAIT : REQ;
                   end
            DRAIN: if (imem_rsp_valid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        // Drain only if a request will still be in flight after this cycle.
        if (redirect_valid) begin
            if (accept || ((state == WAIT || state == DRAIN) && !imem_rsp_valid))
                state_nxt = DRAIN;
            else
                state_nxt = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) pc <= redirect_pc;
            else if (accept)    pc <= pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) req_pc <= pc;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rst_stale <= (rst_stale || state == WAIT || state == DRAIN) && !imem_rsp_valid;
        else if (imem_rsp_valid)
            rst_stale <= 1'b0;
    end

    assign push_entry.pc    = FETCH_XLEN_MAX'(req_pc);
    assign push_entry.instr = FETCH_XLEN_MAX'(imem_rsp_data);

    fetch_queue #(
        .DEPTH   (IQ_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign imem_req_valid = req_valid_c && !rst;
    assign imem_req_addr  = rst ? RESET_PC : pc;
    assign if_valid       = !q_empty && !rst;
    assign if_pc          = rst ? RESET_PC : q_head.pc[XLEN-1:0];
    assign if_instr       = q_head.instr[XLEN-1:0];

    if (XLEN < FETCH_XLEN_MAX) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{q_head.pc[FETCH_XLEN_MAX-1:XLEN], q_head.instr[FETCH_XLEN_MAX-1:XLEN]};
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop)            perf_fetched <= sat_add32(perf_fetched, 32'd1);
            if (redirect_valid) perf_flushed <= sat_add32(perf_flushed, 32'(q_count));
        end
    end
`endif

endmodule
